// File: rtl/vga_hvsync_generator.sv
// rtl/vga_hvsync_generator.sv - VGA raster timing generator (sync, blanking, beam position)
module vga_hvsync_generator #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] hpos,
   output logic [9:0] vpos
);

   // Line and frame geometry, all in the 10-bit counter domain.
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [9:0] hpos_q, hpos_d;
   logic [9:0] vpos_q, vpos_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       h_wrap;
   logic       v_wrap;

   // Next beam position: hpos free-runs, vpos steps only on the hpos wrap.
   always_comb begin
      h_wrap = (hpos_q == H_MAX);
      v_wrap = (vpos_q == V_MAX);
      hpos_d = hpos_q + 10'd1;
      vpos_d = vpos_q;
      if (h_wrap) begin
         hpos_d = 10'd0;
         if (v_wrap) begin
            vpos_d = 10'd0;
         end else begin
            vpos_d = vpos_q + 10'd1;
         end
      end
   end

   // Sync levels are decoded from the next position so the registered
   // pulses line up with the coordinates they belong to (no lag).
   always_comb begin
      hsync_d = 1'b1;
      vsync_d = 1'b1;
      if ((hpos_d >= HS_START) && (hpos_d <= HS_END)) begin
         hsync_d = 1'b0;
      end
      if ((vpos_d >= VS_START) && (vpos_d <= VS_END)) begin
         vsync_d = 1'b0;
      end
   end

   // Beam and sync registers; reset parks the beam at (0,0) with syncs idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hpos_q  <= 10'd0;
         vpos_q  <= 10'd0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         hpos_q  <= hpos_d;
         vpos_q  <= vpos_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign hpos       = hpos_q;
   assign vpos       = vpos_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// tb/tb_vga_hvsync_generator.sv - directed checks of VGA timing on default and reduced geometries
module tb_vga_hvsync_generator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // a: default 640x480 timing
   logic       a_rst_n = 1'b0;
   logic       a_hs, a_vs, a_de;
   logic [9:0] a_hpos, a_vpos;
   // b: default horizontal, short frame (V 4/1/2/2 -> 9 lines, vsync lines 5..6)
   logic       b_rst_n = 1'b0;
   logic       b_hs, b_vs, b_de;
   logic [9:0] b_hpos, b_vpos;
   // c: tiny geometry (14 x 7)
   logic       c_rst_n = 1'b0;
   logic       c_hs, c_vs, c_de;
   logic [9:0] c_hpos, c_vpos;

   vga_hvsync_generator u_a (
      .clk(clk), .rst_n(a_rst_n), .hsync(a_hs), .vsync(a_vs),
      .display_on(a_de), .hpos(a_hpos), .vpos(a_vpos)
   );

   vga_hvsync_generator #(
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
   ) u_b (
      .clk(clk), .rst_n(b_rst_n), .hsync(b_hs), .vsync(b_vs),
      .display_on(b_de), .hpos(b_hpos), .vpos(b_vpos)
   );

   vga_hvsync_generator #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
   ) u_c (
      .clk(clk), .rst_n(c_rst_n), .hsync(c_hs), .vsync(c_vs),
      .display_on(c_de), .hpos(c_hpos), .vpos(c_vpos)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int  fall, rise, lo, doff, pre_v;
   logic prev_hs, prev_de;
   int  t0, t1, l0, l1, vs_lo, de_cnt, de_bad, vs_bad, hs_bad, hs_lo;
   bit  expect_zero, wrap_ok, found;

   initial begin
      // ---------------- reset state ----------------
      repeat (3) step();
      chk("rst_hpos", a_hpos, 0);
      chk("rst_vpos", a_vpos, 0);
      chk("rst_hsync", a_hs, 1);
      chk("rst_vsync", a_vs, 1);
      chk("rst_display_on", a_de, 1);
      a_rst_n = 1'b1;
      step();
      chk("rel_hpos", a_hpos, 1);
      chk("rel_vpos", a_vpos, 0);

      // ---------------- horizontal timing (default) ----------------
      fall = -1; rise = -1; lo = 0; doff = -1; pre_v = -1;
      prev_hs = a_hs; prev_de = a_de;
      for (int i = 0; i < 799; i++) begin
         if (!a_hs) lo++;
         if (!a_hs && prev_hs && fall < 0) fall = int'(a_hpos);
         if (a_hs && !prev_hs && rise < 0) rise = int'(a_hpos);
         if (!a_de && prev_de && doff < 0) doff = int'(a_hpos);
         if (a_hpos == 10'd799) pre_v = int'(a_vpos);
         prev_hs = a_hs;
         prev_de = a_de;
         step();
      end
      chk("h_fall", fall, 656);
      chk("h_rise", rise, 752);
      chk("h_low_cycles", lo, 96);
      chk("de_fall", doff, 640);
      chk("prewrap_vpos", pre_v, 0);
      chk("wrap_hpos", a_hpos, 0);
      chk("wrap_vpos", a_vpos, 1);
      chk("wrap_hsync", a_hs, 1);

      // ---------------- vertical timing / frame wrap (short frame) ----------------
      b_rst_n = 1'b1;
      step();
      chk("b_rel_hpos", b_hpos, 1);
      t0 = -1; t1 = -1; vs_lo = 0; de_cnt = 0; de_bad = 0; vs_bad = 0;
      expect_zero = 0; wrap_ok = 0;
      for (int i = 0; i < 14410; i++) begin
         if (b_hpos == 10'd0 && b_vpos == 10'd0) begin
            if (t0 < 0) t0 = i;
            else if (t1 < 0) t1 = i;
         end
         if (expect_zero) begin
            wrap_ok = (b_hpos == 10'd0) && (b_vpos == 10'd0);
            expect_zero = 0;
         end
         if (b_hpos == 10'd799 && b_vpos == 10'd8) expect_zero = 1;
         if (t0 >= 0 && t1 < 0) begin
            if (!b_vs) vs_lo++;
            if (b_de) de_cnt++;
            if (b_vpos >= 10'd4 && b_de) de_bad++;
            if (b_vs == (b_vpos == 10'd5 || b_vpos == 10'd6)) vs_bad++;
         end
         if (t1 >= 0) break;
         step();
      end
      chk("frame_period", t1 - t0, 7200);
      chk("vsync_low_cycles", vs_lo, 1600);
      chk("vsync_lines", vs_bad, 0);
      chk("visible_count", de_cnt, 2560);
      chk("blank_lines_de", de_bad, 0);
      chk("frame_wrap_00", wrap_ok, 1);

      // ---------------- mid-operation reset during both pulses ----------------
      found = 0;
      for (int i = 0; i < 8000; i++) begin
         if (b_hpos == 10'd700 && b_vpos == 10'd5) begin
            found = 1;
            break;
         end
         step();
      end
      chk("mid_reached", found, 1);
      chk("mid_hsync_pre", b_hs, 0);
      chk("mid_vsync_pre", b_vs, 0);
      b_rst_n = 1'b0;
      step();
      chk("mid_hpos", b_hpos, 0);
      chk("mid_vpos", b_vpos, 0);
      chk("mid_hsync", b_hs, 1);
      chk("mid_vsync", b_vs, 1);
      b_rst_n = 1'b1;
      step();
      chk("mid_rel_hpos", b_hpos, 1);
      repeat (10) step();
      chk("mid_run_hpos", b_hpos, 11);
      chk("mid_run_vpos", b_vpos, 0);

      // ---------------- parameter override (14 x 7) ----------------
      c_rst_n = 1'b1;
      step();
      chk("c_rel_hpos", c_hpos, 1);
      t0 = -1; t1 = -1; l0 = -1; l1 = -1;
      vs_lo = 0; hs_lo = 0; de_cnt = 0; hs_bad = 0; vs_bad = 0; de_bad = 0;
      for (int i = 0; i < 300; i++) begin
         if (c_hpos == 10'd0) begin
            if (l0 < 0) l0 = i;
            else if (l1 < 0) l1 = i;
         end
         if (c_hpos == 10'd0 && c_vpos == 10'd0) begin
            if (t0 < 0) t0 = i;
            else if (t1 < 0) t1 = i;
         end
         if (c_hs == (c_hpos == 10'd10 || c_hpos == 10'd11)) hs_bad++;
         if (c_vs == (c_vpos == 10'd5)) vs_bad++;
         if (c_de != (c_hpos < 10'd8 && c_vpos < 10'd4)) de_bad++;
         if (c_hpos > 10'd13 || c_vpos > 10'd6) de_bad++;
         if (t0 >= 0 && t1 < 0) begin
            if (!c_vs) vs_lo++;
            if (!c_hs) hs_lo++;
            if (c_de) de_cnt++;
         end
         if (t1 >= 0) break;
         step();
      end
      chk("c_line_period", l1 - l0, 14);
      chk("c_frame_period", t1 - t0, 98);
      chk("c_hsync_map", hs_bad, 0);
      chk("c_vsync_map", vs_bad, 0);
      chk("c_de_range", de_bad, 0);
      chk("c_hsync_low", hs_lo, 14);
      chk("c_vsync_low", vs_lo, 14);
      chk("c_visible", de_cnt, 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_hvsync_generator.md
# vga_hvsync_generator

VGA 640x480@60 Hz raster timing generator. It produces horizontal and vertical sync, a display-enable flag and the current beam coordinates, all advancing once per pixel clock (25.175 MHz nominal). Downstream pixel and sprite logic uses it directly: `hpos`/`vpos` address the frame, `display_on` blanks colour, and `hpos==0 && vpos==0` serves as the once-per-frame update tick.

## Interface
Parameters:
- `H_DISPLAY`, default 640: visible pixels per line.
- `H_FRONT`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync pulse width, in pixels.
- `H_BACK`, default 48: horizontal back porch, in pixels.
- `V_DISPLAY`, default 480: visible lines per frame.
- `V_FRONT`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync pulse width, in lines.
- `V_BACK`, default 33: vertical back porch, in lines.

Ports:
- `clk`, in, 1: pixel clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `hsync`, out, 1: horizontal sync, active-low, registered.
- `vsync`, out, 1: vertical sync, active-low, registered.
- `display_on`, out, 1: high when the beam is inside the visible area.
- `hpos`, out, 10: current column, range 0..H_TOTAL-1.
- `vpos`, out, 10: current line, range 0..V_TOTAL-1.

## Operation
- Derived values:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800.
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525.
- Horizontal counter `hpos`:
  - Increments by 1 every clk.
  - At H_TOTAL-1 (799), the next value is 0 (wrap).
- Vertical counter `vpos`:
  - Increments only in the cycle where `hpos` wraps 799→0.
  - If `vpos` = V_TOTAL-1 (524) at that moment, it wraps to 0; the frame ends.
- `hsync`:
  - 0 exactly while `hpos` ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751].
  - 1 otherwise.
- `vsync`:
  - 0 exactly while `vpos` ∈ [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490, 491].
  - 1 otherwise, regardless of `hpos`.
- `display_on` = (`hpos` < H_DISPLAY) && (`vpos` < V_DISPLAY). It is combinational from the counter registers.
- Sync registers are computed from the next counter values, so `hsync`/`vsync` are cycle-aligned with the `hpos`/`vpos` they correspond to. There is no lag.
- All 10-bit arithmetic is unsigned. Counters never exceed their TOTAL-1.

## Timing
- Reset (`rst_n`=0 at a clk edge):
  - Next state: `hpos`=0, `vpos`=0, `hsync`=1, `vsync`=1.
  - `display_on` therefore reads 1.
  - Reset has priority over counting.
  - Reset mid-line or mid-sync-pulse ends the pulse immediately on the next edge.
- First rising edge with `rst_n`=1 after reset: `hpos` goes to 1. Line 0 pixel 0 lasts exactly one cycle after release.
- Line period: 800 cycles.
  - Visible: hpos 0–639.
  - Front porch: 640–655.
  - Sync: 656–751.
  - Back porch: 752–799.
- Frame period: 800×525 = 420000 cycles.
  - Visible: vpos 0–479.
  - Front porch: 480–489.
  - Sync: 490–491.
  - Back porch: 492–524.
- Simultaneous wrap at (799,524): the next cycle is (0,0). Both counters update on the same edge.
- The condition `hpos`==0 && `vpos`==0 is true for exactly one cycle per frame.
- No handshake; free-running whenever out of reset.

## Test plan
- Reset release:
  - Hold `rst_n`=0 for 3 cycles, then release.
  - Before release: `hpos`=0, `vpos`=0, `hsync`=1, `vsync`=1, `display_on`=1.
  - After 1 clk: `hpos`=1.
- Horizontal timing:
  - Run 1 line from reset.
  - `hsync` falls at `hpos`=656 and rises at `hpos`=752; low for 96 cycles.
  - `display_on` falls at `hpos`=640.
  - `hpos` wraps 799→0 and `vpos` goes 0→1 on the same edge.
- Vertical timing:
  - Run 1 frame.
  - `vsync` low for exactly 1600 cycles, from (0,490) through (799,491).
  - `display_on` is 0 for all of `vpos` 480–524.
- Frame wrap:
  - At (799,524), the next cycle is (0,0).
  - Consecutive (0,0) occurrences are exactly 420000 cycles apart.
  - Visible-pixel count per frame (cycles with `display_on`=1) is 307200.
- Mid-operation reset:
  - Assert `rst_n`=0 at (700,490), during both sync pulses.
  - Next cycle: (0,0), `hsync`=1, `vsync`=1.
  - Counting resumes normally after release.
- Parameter override:
  - Instantiate with H_DISPLAY=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_DISPLAY=4, V_FRONT=1, V_SYNC=1, V_BACK=1.
  - Line period is 14 cycles; frame period is 98 cycles.
  - `hsync` is low at `hpos` 10–11; `vsync` is low at `vpos` 5.
